mult_result_collector: RTL and testbench

- Downstream stage of the pipelined multiplier.
- Tracks which multiplier output cycles carry valid products using a valid delay line matched to the multiplier latency.
- Captures valid products into a show-ahead FIFO with a read handshake, and keeps a running wrap-around accumulator of all captured products.
- Gives the top level a lossless, observable result stream, with a sticky flag that records any dropped result.

---
 rtl/mult_result_collector.sv | 123 ++++++++++++
 tb/tb_mult_result_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_collector.sv
// Collects products from a pipelined multiplier: a valid delay line matched to the multiplier
// latency, a show-ahead result FIFO with a sticky drop flag, and a wrap-around accumulator.
module mult_result_collector #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned PW      = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue,
    input  logic [PW-1:0]              product,
    input  logic                       acc_clr,
    input  logic                       ovf_clr,
    input  logic                       rd_en,
    output logic [PW-1:0]              rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [AW-1:0]              acc,
    output logic                       overflow
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;

    // Valid delay line: stage LATENCY-1 lines up with the product on the multiplier output.
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    logic               cap;

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            overflow_q, overflow_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = issue;
        for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

    assign cap   = valid_q[LATENCY-1];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // rd_en is qualified against pre-edge occupancy, so a pop on an empty FIFO is a no-op.
    assign pop  = rd_en && !empty;
    assign push = cap && (!full || pop);
    assign drop = cap && full && !rd_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
    end

    // Clear takes priority but still folds in a product captured the same cycle.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = cap ? AW'(product) : '0;
        end else if (cap) begin
            acc_d = acc_q + AW'(product);
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= product;
        end
    end

    assign rd_data  = empty ? '0 : mem[rd_ptr_q];
    assign rd_valid = !empty;
    assign count    = count_q;
    assign acc      = acc_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_result_collector.sv
// Directed bench for mult_result_collector (LATENCY=2, PW=8, DEPTH=4, AW=16).
module tb_mult_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue;
    logic [7:0]  product;
    logic        acc_clr;
    logic        ovf_clr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [2:0]  count;
    logic [15:0] acc;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    mult_result_collector #(
        .LATENCY(2),
        .PW     (8),
        .DEPTH  (4),
        .AW     (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .issue   (issue),
        .product (product),
        .acc_clr (acc_clr),
        .ovf_clr (ovf_clr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .count   (count),
        .acc     (acc),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        issue   = 1'b0;
        product = 8'h00;
        acc_clr = 1'b0;
        ovf_clr = 1'b0;
        rd_en   = 1'b0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_ovf", 32'(overflow), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();

        // Latency: only the product two cycles after issue is captured.
        issue   = 1'b1;
        product = 8'hAA;
        step();
        issue   = 1'b0;
        product = 8'hBB;
        check("lat_early_count", 32'(count), 0);
        step();
        product = 8'h0F;
        check("lat_pre_count", 32'(count), 0);
        step();
        product = 8'h00;
        check("lat_count", 32'(count), 1);
        check("lat_data", 32'(rd_data), 32'h0F);
        check("lat_valid", 32'(rd_valid), 1);
        check("lat_acc", 32'(acc), 15);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("lat_pop_count", 32'(count), 0);
        check("lat_pop_data", 32'(rd_data), 0);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        check("lat_clr_acc", 32'(acc), 0);

        // Burst of six into a four-entry FIFO: products 5 and 6 are dropped.
        for (int i = 0; i < 8; i++) begin
            issue   = (i < 6);
            product = (i >= 2) ? 8'(i - 1) : 8'h00;
            step();
            if (i == 5) begin
                check("burst_full_count", 32'(count), 4);
                check("burst_no_ovf", 32'(overflow), 0);
            end
            if (i == 6) check("burst_ovf_set", 32'(overflow), 1);
        end
        issue   = 1'b0;
        product = 8'h00;
        check("burst_count", 32'(count), 4);
        check("burst_acc", 32'(acc), 21);
        check("burst_ovf", 32'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);
        for (int j = 0; j < 4; j++) begin
            check("burst_order", 32'(rd_data), 32'(j + 1));
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        check("burst_drained", 32'(count), 0);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 6; i++) begin
            issue   = (i < 4);
            product = (i >= 2) ? 8'(i - 1) : 8'h00;
            step();
        end
        issue = 1'b1;
        check("pp_full", 32'(count), 4);
        step();
        issue = 1'b0;
        step();
        product = 8'h09;
        rd_en   = 1'b1;
        step();
        rd_en   = 1'b0;
        product = 8'h00;
        check("pp_count", 32'(count), 4);
        check("pp_ovf", 32'(overflow), 0);
        check("pp_acc", 32'(acc), 19);
        check("pp_d0", 32'(rd_data), 2);
        rd_en = 1'b1;
        step();
        check("pp_d1", 32'(rd_data), 3);
        step();
        check("pp_d2", 32'(rd_data), 4);
        step();
        check("pp_d3", 32'(rd_data), 9);
        step();
        rd_en = 1'b0;
        check("pp_empty", 32'(count), 0);

        // Accumulator wrap: 258 * 0xFF = 65790 = 0x100FE.
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        product = 8'hFF;
        for (int i = 0; i < 260; i++) begin
            issue = (i < 258);
            step();
        end
        product = 8'h00;
        check("acc_wrap", 32'(acc), 32'h00FE);
        rd_en   = 1'b1;
        ovf_clr = 1'b1;
        repeat (4) step();
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        check("wrap_drained", 32'(count), 0);
        issue = 1'b1;
        step();
        issue = 1'b0;
        step();
        product = 8'h05;
        acc_clr = 1'b1;
        step();
        product = 8'h00;
        check("clr_cap_acc", 32'(acc), 5);
        check("clr_cap_count", 32'(count), 1);
        check("clr_cap_data", 32'(rd_data), 5);
        step();
        acc_clr = 1'b0;
        check("clr_only_acc", 32'(acc), 0);
        rd_en = 1'b1;
        step();

        // Underflow: rd_en held on empty, then a push alongside rd_en on empty.
        for (int k = 0; k < 3; k++) begin
            step();
            check("uf_count", 32'(count), 0);
            check("uf_valid", 32'(rd_valid), 0);
            check("uf_data", 32'(rd_data), 0);
        end
        issue = 1'b1;
        step();
        issue = 1'b0;
        step();
        product = 8'h33;
        step();
        rd_en   = 1'b0;
        product = 8'h00;
        check("uf_push_count", 32'(count), 1);
        check("uf_push_data", 32'(rd_data), 32'h33);
        check("uf_push_acc", 32'(acc), 32'h33);

        // Asynchronous reset mid-flight discards the pending issue.
        issue = 1'b1;
        step();
        issue   = 1'b0;
        product = 8'h77;
        rst_n   = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_acc", 32'(acc), 0);
        check("ar_ovf", 32'(overflow), 0);
        check("ar_valid", 32'(rd_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_nocap_count", 32'(count), 0);
        check("ar_nocap_acc", 32'(acc), 0);
        product = 8'h00;
        step();
        check("ar_late_count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
